// File: rtl/pong_pkg.sv
// Shared constants, types and helpers for the Pong pixel renderer.
// Geometry is 16-bit typed so comparisons against pixel coordinates stay width-matched.
package pong_pkg;

  localparam logic [15:0] H_ACTIVE  = 16'd1280;
  localparam logic [15:0] V_ACTIVE  = 16'd720;
  localparam logic [15:0] PADDLE_W  = 16'd16;
  localparam logic [15:0] PADDLE_H  = 16'd128;
  localparam logic [15:0] PADDLE_XL = 16'd64;
  localparam logic [15:0] PADDLE_XR = 16'd1200;
  localparam logic [15:0] BALL_SZ   = 16'd16;
  localparam logic [15:0] NET_W     = 16'd8;
  localparam logic [15:0] NET_DASH  = 16'd32;
  localparam logic [15:0] NET_X0    = (H_ACTIVE >> 1) - (NET_W >> 1);

  localparam logic [15:0] DIGIT_W   = 16'd48;
  localparam logic [15:0] DIGIT_H   = 16'd80;
  localparam logic [15:0] SEG_T     = 16'd8;
  localparam logic [15:0] DIGIT_L_X = 16'd560;
  localparam logic [15:0] DIGIT_R_X = 16'd672;
  localparam logic [15:0] DIGIT_Y   = 16'd32;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_GREY  = 24'h808080;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  typedef struct packed {
    logic [15:0] paddle_l_y;
    logic [15:0] paddle_r_y;
    logic [15:0] ball_x;
    logic [15:0] ball_y;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
  } game_t;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

  // Segment mask {a,b,c,d,e,f,g}; codes 10..15 fall through to the pattern for 9.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] mask;
    case (digit)
      4'd0:    mask = 7'b1111110;
      4'd1:    mask = 7'b0110000;
      4'd2:    mask = 7'b1101101;
      4'd3:    mask = 7'b1111001;
      4'd4:    mask = 7'b0110011;
      4'd5:    mask = 7'b1011011;
      4'd6:    mask = 7'b1011111;
      4'd7:    mask = 7'b1110000;
      4'd8:    mask = 7'b1111111;
      default: mask = 7'b1111011;
    endcase
    return mask;
  endfunction

  // Half-open span test [lo, lo+size) done in 17 bits so the upper bound never wraps.
  function automatic logic in_span(input logic [15:0] v, input logic [15:0] lo,
                                   input logic [15:0] size);
    logic [16:0] v_w;
    logic [16:0] lo_w;
    v_w  = {1'b0, v};
    lo_w = {1'b0, lo};
    return (v_w >= lo_w) && (v_w < lo_w + {1'b0, size});
  endfunction

endpackage

// File: rtl/pong_pixel_renderer_digit_hit.sv
// One 7-segment score digit: registered hit flag for the pixel at (x, y),
// aligned with the renderer's first pipeline stage.
module pong_digit_hit
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [3:0]  digit,
  input  logic [15:0] box_x,
  input  logic [15:0] box_y,
  output logic        hit
);

  localparam logic [15:0] SEG_RIGHT = DIGIT_W - SEG_T;
  localparam logic [15:0] MID_LO    = (DIGIT_H >> 1) - (SEG_T >> 1);
  localparam logic [15:0] MID_HI    = (DIGIT_H >> 1) + (SEG_T >> 1);
  localparam logic [15:0] SEG_BOT   = DIGIT_H - SEG_T;

  logic [6:0]  seg;
  logic        in_box;
  logic [15:0] dx;
  logic [15:0] dy;
  logic        hit_d;
  logic        hit_q;

  // NOTE: every signal written in a combinational block gets a default first, so no latch can form.
  always_comb begin
    seg    = seg_decode(digit);
    in_box = in_span(x, box_x, DIGIT_W) && in_span(y, box_y, DIGIT_H);
    dx     = x - box_x;
    dy     = y - box_y;
    hit_d  = 1'b0;
    if (in_box) begin
      hit_d = (seg[6] && (dy < SEG_T))
           || (seg[5] && (dx >= SEG_RIGHT) && (dy < MID_HI))
           || (seg[4] && (dx >= SEG_RIGHT) && (dy >= MID_LO))
           || (seg[3] && (dy >= SEG_BOT))
           || (seg[2] && (dx < SEG_T) && (dy >= MID_LO))
           || (seg[1] && (dx < SEG_T) && (dy < MID_HI))
           || (seg[0] && (dy >= MID_LO) && (dy < MID_HI));
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/pong_pixel_renderer.sv
// Pong scene renderer: per-frame shadowed game state, two-stage pixel pipeline
// (hit flags, then priority colour mux) with syncs delayed to match.
module pong_pixel_renderer
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        active_in,
  input  logic [15:0] paddle_l_y,
  input  logic [15:0] paddle_r_y,
  input  logic [15:0] ball_x,
  input  logic [15:0] ball_y,
  input  logic [3:0]  score_l,
  input  logic [3:0]  score_r,
  output logic [23:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_out,
  output logic        frame_start
);

  logic        vsync_d,       vsync_q;
  logic        frame_start_d, frame_start_q;
  logic        vs_rise;
  game_t       game_d,        game_q;

  sync_t       sync_s1_d,     sync_s1_q;
  logic        ball_hit_d,    ball_hit_q;
  logic        pad_l_hit_d,   pad_l_hit_q;
  logic        pad_r_hit_d,   pad_r_hit_q;
  logic        net_hit_d,     net_hit_q;
  logic        score_l_hit,   score_r_hit;
  logic        on_screen;

  sync_t       sync_s2_d,     sync_s2_q;
  logic [23:0] rgb_d,         rgb_q;

  // Shadow game state: captured only on the vsync rising edge so a frame never tears.
  always_comb begin
    vsync_d       = vsync_in;
    vs_rise       = vsync_in & ~vsync_q;
    frame_start_d = vs_rise;
    game_d        = game_q;
    if (vs_rise) begin
      game_d.paddle_l_y = paddle_l_y;
      game_d.paddle_r_y = paddle_r_y;
      game_d.ball_x     = ball_x;
      game_d.ball_y     = ball_y;
      game_d.score_l    = score_l;
      game_d.score_r    = score_r;
    end
  end

  // Stage 1: object hit flags, clipped to the active area.
  always_comb begin
    on_screen   = (x < H_ACTIVE) && (y < V_ACTIVE);
    ball_hit_d  = on_screen && in_span(x, game_q.ball_x, BALL_SZ)
                            && in_span(y, game_q.ball_y, BALL_SZ);
    pad_l_hit_d = on_screen && in_span(x, PADDLE_XL, PADDLE_W)
                            && in_span(y, game_q.paddle_l_y, PADDLE_H);
    pad_r_hit_d = on_screen && in_span(x, PADDLE_XR, PADDLE_W)
                            && in_span(y, game_q.paddle_r_y, PADDLE_H);
    net_hit_d   = on_screen && in_span(x, NET_X0, NET_W)
                            && ((y % NET_DASH) < (NET_DASH >> 1));
    sync_s1_d.active = active_in;
    sync_s1_d.hsync  = hsync_in;
    sync_s1_d.vsync  = vsync_in;
  end

  pong_digit_hit u_digit_l (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .digit (game_q.score_l),
    .box_x (DIGIT_L_X),
    .box_y (DIGIT_Y),
    .hit   (score_l_hit)
  );

  pong_digit_hit u_digit_r (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .digit (game_q.score_r),
    .box_x (DIGIT_R_X),
    .box_y (DIGIT_Y),
    .hit   (score_r_hit)
  );

  // Stage 2: priority mux, blanked outside the active area.
  always_comb begin
    sync_s2_d = sync_s1_q;
    rgb_d     = RGB_BLACK;
    if (sync_s1_q.active) begin
      if (ball_hit_q) begin
        rgb_d = RGB_WHITE;
      end else if (pad_l_hit_q || pad_r_hit_q) begin
        rgb_d = RGB_WHITE;
      end else if (score_l_hit || score_r_hit) begin
        rgb_d = RGB_WHITE;
      end else if (net_hit_q) begin
        rgb_d = RGB_GREY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      game_q        <= '0;
      sync_s1_q     <= '0;
      ball_hit_q    <= 1'b0;
      pad_l_hit_q   <= 1'b0;
      pad_r_hit_q   <= 1'b0;
      net_hit_q     <= 1'b0;
      sync_s2_q     <= '0;
      rgb_q         <= RGB_BLACK;
    end else begin
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      game_q        <= game_d;
      sync_s1_q     <= sync_s1_d;
      ball_hit_q    <= ball_hit_d;
      pad_l_hit_q   <= pad_l_hit_d;
      pad_r_hit_q   <= pad_r_hit_d;
      net_hit_q     <= net_hit_d;
      sync_s2_q     <= sync_s2_d;
      rgb_q         <= rgb_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync_out   = sync_s2_q.hsync;
  assign vsync_out   = sync_s2_q.vsync;
  assign active_out  = sync_s2_q.active;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_pong_pixel_renderer.sv
// Directed bench for pong_pixel_renderer: hand-computed pixel colours per scene,
// shadow-load timing, reset behaviour and sync delay.
module tb_pong_pixel_renderer;

  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] G = 24'h808080;
  localparam logic [23:0] K = 24'h000000;

  typedef struct {
    int          px;
    int          py;
    logic [23:0] exp;
  } pix_vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y;
  logic        hsync_in, vsync_in, active_in;
  logic [15:0] paddle_l_y, paddle_r_y, ball_x, ball_y;
  logic [3:0]  score_l, score_r;
  logic [23:0] rgb;
  logic        hsync_out, vsync_out, active_out, frame_start;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pong_pixel_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .active_in   (active_in),
    .paddle_l_y  (paddle_l_y),
    .paddle_r_y  (paddle_r_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .score_l     (score_l),
    .score_r     (score_r),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .active_out  (active_out),
    .frame_start (frame_start)
  );

  // Drive one active pixel and return the colour that emerges two cycles later.
  task automatic pix(input int px, input int py, output logic [23:0] c);
    @(negedge clk);
    x         = 16'(px);
    y         = 16'(py);
    active_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    c = rgb;
  endtask

  task automatic set_game(input int pl, input int pr, input int bx, input int by,
                          input int sl, input int sr);
    @(negedge clk);
    paddle_l_y = 16'(pl);
    paddle_r_y = 16'(pr);
    ball_x     = 16'(bx);
    ball_y     = 16'(by);
    score_l    = 4'(sl);
    score_r    = 4'(sr);
  endtask

  task automatic do_vsync();
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
    vsync_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (rgb !== K) begin n_err++; $display("FAIL reset rgb: got %h want %h", rgb, K); end
    n_vec++; if (hsync_out !== 1'b0) begin n_err++; $display("FAIL reset hsync_out: got %b want 0", hsync_out); end
    n_vec++; if (vsync_out !== 1'b0) begin n_err++; $display("FAIL reset vsync_out: got %b want 0", vsync_out); end
    n_vec++; if (active_out !== 1'b0) begin n_err++; $display("FAIL reset active_out: got %b want 0", active_out); end
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset frame_start: got %b want 0", frame_start); end
    reset = 1'b0;
  endtask

  task automatic test_paddle();
    pix_vec_t tbl [6] = '{'{64, 300, W}, '{63, 300, K}, '{80, 300, K},
                          '{79, 427, W}, '{64, 428, K}, '{64, 299, K}};
    logic [23:0] got;
    set_game(300, 0, 0, 0, 0, 0);
    do_vsync();
    foreach (tbl[i]) begin
      pix(tbl[i].px, tbl[i].py, got);
      n_vec++;
      if (got !== tbl[i].exp) begin
        n_err++;
        $display("FAIL paddle (%0d,%0d): got %h want %h", tbl[i].px, tbl[i].py, got, tbl[i].exp);
      end
    end
  endtask

  task automatic test_ball();
    pix_vec_t tbl_a [4] = '{'{0, 0, W}, '{15, 15, W}, '{16, 0, K}, '{0, 16, K}};
    pix_vec_t tbl_b [5] = '{'{1270, 5, W}, '{1279, 15, W}, '{1269, 5, K},
                            '{0, 5, K}, '{1280, 5, K}};
    logic [23:0] got;
    foreach (tbl_a[i]) begin
      pix(tbl_a[i].px, tbl_a[i].py, got);
      n_vec++;
      if (got !== tbl_a[i].exp) begin
        n_err++;
        $display("FAIL ball origin (%0d,%0d): got %h want %h", tbl_a[i].px, tbl_a[i].py, got, tbl_a[i].exp);
      end
    end
    set_game(300, 0, 1270, 0, 0, 0);
    do_vsync();
    foreach (tbl_b[i]) begin
      pix(tbl_b[i].px, tbl_b[i].py, got);
      n_vec++;
      if (got !== tbl_b[i].exp) begin
        n_err++;
        $display("FAIL ball edge (%0d,%0d): got %h want %h", tbl_b[i].px, tbl_b[i].py, got, tbl_b[i].exp);
      end
    end
  endtask

  task automatic test_midframe();
    pix_vec_t tbl [4] = '{'{1200, 400, W}, '{1215, 527, W}, '{1200, 150, K}, '{1216, 400, K}};
    logic [23:0] got;
    set_game(300, 100, 1270, 0, 0, 0);
    do_vsync();
    pix(1200, 150, got);
    n_vec++; if (got !== W) begin n_err++; $display("FAIL midframe old pos: got %h want %h", got, W); end
    pix(1200, 360, got);
    set_game(300, 400, 1270, 0, 0, 0);
    pix(1200, 400, got);
    n_vec++; if (got !== K) begin n_err++; $display("FAIL midframe early new pos: got %h want %h", got, K); end
    pix(1200, 150, got);
    n_vec++; if (got !== W) begin n_err++; $display("FAIL midframe kept old pos: got %h want %h", got, W); end
    @(negedge clk);
    vsync_in = 1'b1;
    @(negedge clk);
    n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL frame_start pulse: got %b want 1", frame_start); end
    vsync_in = 1'b0;
    @(negedge clk);
    n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL frame_start width: got %b want 0", frame_start); end
    foreach (tbl[i]) begin
      pix(tbl[i].px, tbl[i].py, got);
      n_vec++;
      if (got !== tbl[i].exp) begin
        n_err++;
        $display("FAIL midframe new (%0d,%0d): got %h want %h", tbl[i].px, tbl[i].py, got, tbl[i].exp);
      end
    end
  endtask

  task automatic test_score();
    pix_vec_t tbl_a [15] = '{'{580, 34, W}, '{604, 52, W}, '{604, 92, W}, '{580, 108, W},
                             '{562, 92, W}, '{562, 52, W}, '{580, 72, W}, '{580, 52, K},
                             '{608, 34, K}, '{559, 34, K},
                             '{716, 52, W}, '{716, 92, W}, '{692, 34, K}, '{692, 72, K},
                             '{674, 52, K}};
    pix_vec_t tbl_b [5] = '{'{562, 92, K}, '{580, 108, W}, '{580, 72, W}, '{604, 52, W},
                            '{562, 52, W}};
    logic [23:0] got;
    set_game(300, 400, 1270, 0, 8, 1);
    do_vsync();
    foreach (tbl_a[i]) begin
      pix(tbl_a[i].px, tbl_a[i].py, got);
      n_vec++;
      if (got !== tbl_a[i].exp) begin
        n_err++;
        $display("FAIL score 8/1 (%0d,%0d): got %h want %h", tbl_a[i].px, tbl_a[i].py, got, tbl_a[i].exp);
      end
    end
    set_game(300, 400, 1270, 0, 12, 1);
    do_vsync();
    foreach (tbl_b[i]) begin
      pix(tbl_b[i].px, tbl_b[i].py, got);
      n_vec++;
      if (got !== tbl_b[i].exp) begin
        n_err++;
        $display("FAIL score 12 as 9 (%0d,%0d): got %h want %h", tbl_b[i].px, tbl_b[i].py, got, tbl_b[i].exp);
      end
    end
  endtask

  task automatic test_net();
    pix_vec_t tbl [10] = '{'{640, 200, W}, '{640, 16, K}, '{640, 0, G}, '{636, 0, G},
                           '{635, 0, K}, '{644, 0, K}, '{643, 31, K}, '{643, 32, G},
                           '{640, 719, G}, '{640, 720, K}};
    logic [23:0] got;
    set_game(300, 400, 632, 200, 0, 0);
    do_vsync();
    foreach (tbl[i]) begin
      pix(tbl[i].px, tbl[i].py, got);
      n_vec++;
      if (got !== tbl[i].exp) begin
        n_err++;
        $display("FAIL net (%0d,%0d): got %h want %h", tbl[i].px, tbl[i].py, got, tbl[i].exp);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [23:0] got;
    hsync_in = 1'b1;
    pix(640, 0, got);
    n_vec++; if (got !== G) begin n_err++; $display("FAIL pre-reset rgb: got %h want %h", got, G); end
    n_vec++; if (hsync_out !== 1'b1) begin n_err++; $display("FAIL pre-reset hsync_out: got %b want 1", hsync_out); end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({rgb, active_out, hsync_out, vsync_out} !== 27'd0) begin
        n_err++;
        $display("FAIL midline reset cycle %0d: rgb=%h act=%b hs=%b vs=%b want all 0",
                 c, rgb, active_out, hsync_out, vsync_out);
      end
    end
    reset    = 1'b0;
    hsync_in = 1'b0;
    pix(0, 0, got);
    n_vec++; if (got !== W) begin n_err++; $display("FAIL post-reset ball at origin: got %h want %h", got, W); end
    pix(640, 200, got);
    n_vec++; if (got !== G) begin n_err++; $display("FAIL post-reset shadow cleared: got %h want %h", got, G); end
  endtask

  task automatic test_sync_shift();
    logic [2:0] cur, h1, h2, obs;
    h1 = 3'b000;
    h2 = 3'b000;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      obs = {active_out, hsync_out, vsync_out};
      if (k >= 2) begin
        n_vec++;
        if (obs !== h2) begin
          n_err++;
          $display("FAIL sync delay step %0d: got %b want %b", k, obs, h2);
        end
      end
      cur = {((k % 110) >= 50), ((k % 110) < 40), ((k / 110) % 3 == 1)};
      {active_in, hsync_in, vsync_in} = cur;
      h2 = h1;
      h1 = cur;
    end
  endtask

  initial begin
    reset      = 1'b1;
    x          = '0;
    y          = '0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    active_in  = 1'b0;
    paddle_l_y = '0;
    paddle_r_y = '0;
    ball_x     = '0;
    ball_y     = '0;
    score_l    = '0;
    score_r    = '0;
    test_reset();
    test_paddle();
    test_ball();
    test_midframe();
    test_score();
    test_net();
    test_reset_midline();
    test_sync_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
